// File: rtl/encoder_pkg.sv
// Shared types, opcode/funct constants and the MIPS-style word encoder.
package encoder_pkg;

    // Request operation codes; 11-15 are illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_JR   = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_ADDI = 4'd6,
        OP_XORI = 4'd7,
        OP_BNE  = 4'd8,
        OP_J    = 4'd9,
        OP_JAL  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned WORD_W = 32;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Producer request payload.
    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_req_t;

    typedef struct packed {
        logic              legal;
        logic [WORD_W-1:0] word;
    } enc_t;

    // Combinational encode of one request; illegal ops yield legal=0.
    function automatic enc_t encode(input instr_req_t r);
        enc_t e;
        e.legal = 1'b1;
        e.word  = '0;
        case (r.op)
            OP_ADD:  e.word = {OPC_RTYPE, r.rs, r.rt, r.rd, 5'd0, FN_ADD};
            OP_SUB:  e.word = {OPC_RTYPE, r.rs, r.rt, r.rd, 5'd0, FN_SUB};
            OP_SLT:  e.word = {OPC_RTYPE, r.rs, r.rt, r.rd, 5'd0, FN_SLT};
            OP_JR:   e.word = {OPC_RTYPE, r.rs, 5'd0, 5'd0, 5'd0, FN_JR};
            OP_LW:   e.word = {OPC_LW,   r.rs, r.rt, r.imm};
            OP_SW:   e.word = {OPC_SW,   r.rs, r.rt, r.imm};
            OP_ADDI: e.word = {OPC_ADDI, r.rs, r.rt, r.imm};
            OP_XORI: e.word = {OPC_XORI, r.rs, r.rt, r.imm};
            OP_BNE:  e.word = {OPC_BNE,  r.rs, r.rt, r.imm};
            OP_J:    e.word = {OPC_J,   r.target};
            OP_JAL:  e.word = {OPC_JAL, r.target};
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding encoded words until memory accepts them.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (occ == (PW+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (PW+1)'(1);
                2'b01:   occ <= occ - (PW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes instruction requests into 32-bit words and streams them into instruction memory.
module instruction_encoder
    import encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    state_e     state;
    state_e     state_nxt;
    instr_req_t req;
    enc_t       enc;
    logic       accept;
    logic       push;
    logic       pop;
    logic       start_ok;
    logic       fifo_full;
    logic       fifo_empty;

    assign req      = {in_op, in_rs, in_rt, in_rd, in_imm, in_target};
    assign enc      = encode(req);
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc.legal;
    assign pop      = mem_we && mem_ready;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (enc.word),
        .pop     (pop),
        .rdata   (mem_wdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; FLUSH leaves once the buffer is observed empty.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (accept && in_last) state_nxt = ST_FLUSH;
            ST_FLUSH: if (fifo_empty) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from state and buffer flags.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_RUN: begin
                in_ready = !fifo_full;
                mem_we   = !fifo_empty;
                busy     = 1'b1;
            end
            ST_FLUSH: begin
                mem_we = !fifo_empty;
                busy   = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Write address, word count and sticky illegal-op flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else if (start_ok) begin
            mem_addr <= base_addr;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (pop) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                count    <= count + (ADDR_W+1)'(1);
            end
            if (accept && !enc.legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder.
module tb_instruction_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy, done, err;
    logic [10:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] log_data[$];
    logic [9:0]  log_addr[$];
    logic [31:0] exp_w[8];

    instruction_encoder #(.ADDR_W(10), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && mem_we && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    endtask

    task automatic start_prog(input logic [9:0] base);
        base_addr = base;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last);
        logic ok;
        ok = 1'b0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic check_log(input string tag, input int n, input logic [9:0] base);
        logic [9:0] a;
        chk({tag, "_nwr"}, 32'(log_data.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < log_data.size()) begin
                a = base + 10'(i);
                chk({tag, "_addr"}, 32'(log_addr[i]), 32'(a));
                chk({tag, "_data"}, log_data[i], exp_w[i]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        in_target = '0; in_last = 1'b0; mem_ready = 1'b1;

        // Reset values
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 0);

        // Single ADD with last, plus one-cycle write latency
        start_prog(10'd0);
        chk("run_busy", 32'(busy), 1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
        chk("lat_mem_we", 32'(mem_we), 1);
        chk("lat_wdata", mem_wdata, 32'h00221820);
        chk("lat_addr", 32'(mem_addr), 0);
        wait_done("add_done");
        chk("add_count", 32'(count), 1);
        chk("add_busy", 32'(busy), 0);
        exp_w[0] = 32'h00221820;
        check_log("add", 1, 10'd0);

        // LW, SW, J, JR at consecutive addresses
        log_data.delete(); log_addr.delete();
        start_prog(10'h010);
        chk("restart_count", 32'(count), 0);
        send(4'd4, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b0);
        send(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b0);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100, 1'b0);
        send(4'd3, 5'd31, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
        wait_done("mix_done");
        exp_w[0] = 32'h8FA80004; exp_w[1] = 32'hAFA80004;
        exp_w[2] = 32'h08000100; exp_w[3] = 32'h03E00008;
        check_log("mix", 4, 10'h010);
        chk("mix_count", 32'(count), 4);
        chk("mix_err", 32'(err), 0);

        // Backpressure: memory stalled, buffer fills after 4 accepts
        log_data.delete(); log_addr.delete();
        mem_ready = 1'b0;
        start_prog(10'h020);
        for (int i = 0; i < 4; i++) send(4'd6, 5'd0, 5'(i), 5'd0, 16'(i), 26'd0, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_mem_we", 32'(mem_we), 1);
        chk("bp_nowrite", 32'(log_data.size()), 0);
        fork
            begin
                repeat (6) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
            begin
                send(4'd6, 5'd0, 5'd4, 5'd0, 16'd4, 26'd0, 1'b0);
                send(4'd6, 5'd0, 5'd5, 5'd0, 16'd5, 26'd0, 1'b1);
            end
        join
        wait_done("bp_done");
        for (int i = 0; i < 6; i++) exp_w[i] = 32'h20000000 | (32'(i) << 16) | 32'(i);
        check_log("bp", 6, 10'h020);
        chk("bp_count", 32'(count), 6);

        // Address wrap from 1023 to 0
        log_data.delete(); log_addr.delete();
        start_prog(10'd1022);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b0);
        send(4'd2, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 1'b0);
        send(4'd10, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF, 1'b1);
        wait_done("wrap_done");
        exp_w[0] = 32'h00853022; exp_w[1] = 32'h00E8482A; exp_w[2] = 32'h0FFFFFFF;
        check_log("wrap", 3, 10'd1022);
        chk("wrap_count", 32'(count), 3);

        // Illegal op is dropped and flags err
        log_data.delete(); log_addr.delete();
        start_prog(10'd0);
        send(4'd7, 5'd5, 5'd5, 5'd0, 16'hFFFF, 26'd0, 1'b0);
        chk("ill_err_before", 32'(err), 0);
        send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1234, 26'd0, 1'b0);
        chk("ill_err_set", 32'(err), 1);
        send(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'd0, 1'b1);
        wait_done("ill_done");
        exp_w[0] = 32'h38A5FFFF; exp_w[1] = 32'h1422FFFE;
        check_log("ill", 2, 10'd0);
        chk("ill_err_sticky", 32'(err), 1);
        chk("ill_count", 32'(count), 2);

        // Reset mid-FLUSH drops buffered words
        log_data.delete(); log_addr.delete();
        mem_ready = 1'b0;
        start_prog(10'h040);
        chk("clr_err", 32'(err), 0);
        send(4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1'b0);
        send(4'd0, 5'd2, 5'd2, 5'd2, 16'd0, 26'd0, 1'b0);
        send(4'd0, 5'd3, 5'd3, 5'd3, 16'd0, 26'd0, 1'b1);
        chk("fl_busy", 32'(busy), 1);
        chk("fl_in_ready", 32'(in_ready), 0);
        chk("fl_mem_we", 32'(mem_we), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_mem_we", 32'(mem_we), 0);
        chk("ar_mem_addr", 32'(mem_addr), 0);
        chk("ar_mem_wdata", mem_wdata, 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_count", 32'(count), 0);
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("ar_nowrite", 32'(log_data.size()), 0);
        chk("ar_idle_we", 32'(mem_we), 0);
        chk("ar_idle_done", 32'(done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 Parameter DEPTH, default 4: encoded-word buffer depth, a power of two and at least 2.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle pulse that loads the address counter from base_addr and enters RUN; ignored outside IDLE/DONE.
REQ-006 Port base_addr, input, ADDR_W: first word address written.
REQ-007 Port in_valid, input, 1: the producer has a valid instruction request.
REQ-008 Port in_ready, output, 1: the block can accept a request; high only in RUN with the buffer not full.
REQ-009 Port in_op, input, 4: operation code, 0 ADD, 1 SUB, 2 SLT, 3 JR, 4 LW, 5 SW, 6 ADDI, 7 XORI, 8 BNE, 9 J, 10 JAL; 11-15 are illegal.
REQ-010 Port in_rs, in_rt, in_rd, input, 5 each: register fields.
REQ-011 Port in_imm, input, 16: I-type immediate; in_target, input, 26: J-type target.
REQ-012 Port in_last, input, 1: marks the final request of a program.
REQ-013 Port mem_we, output, 1; mem_addr, output, ADDR_W; mem_wdata, output, 32: instruction-memory write port.
REQ-014 Port mem_ready, input, 1: memory accepts the write in any cycle where mem_we and mem_ready are both high.
REQ-015 Port busy, output, 1; done, output, 1; err, output, 1 (sticky illegal op); count, output, ADDR_W+1 (words written).

Function
REQ-016 A request transfers when in_valid && in_ready; encoding is combinational and the result is pushed into the buffer in the same cycle.
REQ-017 R-type ops use opcode 000000 with {rs,rt,rd,shamt=0,funct}, with funct ADD 100000, SUB 100010, SLT 101010, and JR 001000 (rt=rd=0).
REQ-018 I-type ops use {opcode,rs,rt,imm}, with opcodes LW 100011, SW 101011, ADDI 001000, XORI 001110, BNE 000101.
REQ-019 J-type ops use {opcode,target}, with opcodes J 000010 and JAL 000011.
REQ-020 An illegal op is accepted but not pushed; it sets err; in_last on an illegal op still ends the program.
REQ-021 The buffer head drives mem_wdata; mem_we = buffer non-empty in RUN/FLUSH; on a write, pop, increment mem_addr and increment count.
REQ-022 mem_addr wraps from 2^ADDR_W-1 to 0 with no error.
REQ-023 A push and a pop in the same cycle leave occupancy unchanged; a push while full is impossible because in_ready is low.
REQ-024 FSM states are IDLE, RUN, FLUSH and DONE.
REQ-025 IDLE goes to RUN on start.
REQ-026 RUN goes to FLUSH when an accepted request has in_last set; in_ready is low from FLUSH onward.
REQ-027 FLUSH goes to DONE in the cycle after the buffer becomes empty.
REQ-028 DONE goes to RUN on start; start in DONE clears count and err.
REQ-029 busy = RUN or FLUSH; done = state DONE (level).
REQ-030 Latency: a request accepted in cycle N with an empty buffer and mem_ready high is written in cycle N+1.

Reset
REQ-031 On reset_n low, asynchronously: state IDLE, buffer empty, mem_we 0, mem_addr 0, mem_wdata 0, count 0, err 0, in_ready 0, busy 0, done 0.
REQ-032 A reset in RUN or FLUSH discards buffered words and no further writes occur.

Structure
REQ-033 A shared package encoder_pkg holds the in_op enumeration, the opcode/funct constants and the FSM state type.
REQ-034 The buffer is one sub-module, instr_fifo (DEPTH x 32, synchronous, with full/empty flags).

Verification
REQ-035 start, base 0, ADD rs=1 rt=2 rd=3 with last -> word 0x00221820 at address 0, then done=1 and count=1.
REQ-036 LW rt=8 rs=29 imm=4, then SW, J target=0x100, JR rs=31 -> 0x8FA80004, 0xAFA80004, 0x08000100 and 0x03E00008 at consecutive addresses.
REQ-037 mem_ready held low for 10 cycles with 6 requests offered -> in_ready low after 4 accepts, then in-order writes with none lost.
REQ-038 base_addr=1022 and 3 requests -> writes at addresses 1022, 1023, then 0.
REQ-039 op 12 between XORI rt=5 rs=5 imm=0xFFFF and BNE rs=1 rt=2 imm=0xFFFE -> err=1 and only 0x38A5FFFF and 0x1422FFFE are written.
REQ-040 reset_n pulsed low mid-FLUSH with 3 buffered words -> outputs at reset values immediately and no writes afterwards.
